qos_ingress: RTL

- Upstream feeder for the qos block; owns the link-side word handshake and drives qos's write side (iniciar, vc_id, data_word).
- Honours qos's per-VC pausa/continuar flow control through one small hold FIFO per virtual channel, so words already in flight are never lost.
- Arbitrates round-robin among unpaused, non-empty VCs and emits at most one word per cycle.
- Sequences qos start-up by pulsing iniciar.

---
 rtl/qos_ingress_pkg.sv | 15 +
 rtl/qos_ingress_hold_fifo.sv | 38 +++
 rtl/qos_ingress.sv | 133 +++++++++++++
 3 files changed

// File: rtl/qos_ingress_pkg.sv
// Shared widths and FSM encoding for the qos ingress feeder.
package qos_ingress_pkg;
  localparam int QUEUE_QUANTITY_D = 4;
  localparam int BUF_WIDTH_D      = 3;
  localparam int HOLD_DEPTH_D     = 4;
  localparam int CNT_BITS_D       = 16;
  localparam int VC_W             = $clog2(QUEUE_QUANTITY_D);
  localparam int DATA_W           = BUF_WIDTH_D + 1;

  typedef enum logic [1:0] {
    ST_CFG   = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;
endpackage

// File: rtl/qos_ingress_hold_fifo.sv
// Per-VC hold FIFO; head word is visible combinationally on o_data.
module qos_ingress_hold_fifo #(
  parameter int DW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr,
  input  logic          i_rd,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr, r_rptr;

  // Extra pointer bit distinguishes full from empty.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_wr) r_wptr <= r_wptr + 1'b1;
      if (i_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/qos_ingress.sv
// Link-side feeder for qos: per-VC hold FIFOs, pause tracking, round-robin push.
module qos_ingress
  import qos_ingress_pkg::*;
#(
  parameter int QUEUE_QUANTITY = QUEUE_QUANTITY_D,
  parameter int BUF_WIDTH      = BUF_WIDTH_D,
  parameter int HOLD_DEPTH     = HOLD_DEPTH_D,
  parameter int CNT_BITS       = CNT_BITS_D,
  parameter int VW             = $clog2(QUEUE_QUANTITY),
  parameter int DW             = BUF_WIDTH + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enb,
  input  logic                      cfg_start,
  input  logic                      in_valid,
  input  logic [VW-1:0]             in_vc,
  input  logic [DW-1:0]             in_data,
  output logic                      in_ready,
  input  logic [QUEUE_QUANTITY-1:0] pausa,
  input  logic [QUEUE_QUANTITY-1:0] continuar,
  input  logic [QUEUE_QUANTITY-1:0] error_full,
  output logic                      iniciar,
  output logic                      push,
  output logic [VW-1:0]             vc_id,
  output logic [DW-1:0]             data_word,
  output logic [QUEUE_QUANTITY-1:0] paused,
  output logic [QUEUE_QUANTITY-1:0] err_sticky,
  output logic [CNT_BITS-1:0]       fwd_count
);
  state_t                           r_state, w_state_nxt;
  logic [QUEUE_QUANTITY-1:0]        r_paused, r_err;
  logic [VW-1:0]                    r_ptr, r_vc, w_win, w_ptr_nxt;
  logic [DW-1:0]                    r_data;
  logic                             r_push;
  logic [CNT_BITS-1:0]              r_cnt;
  logic [QUEUE_QUANTITY-1:0]        w_full, w_empty, w_elig, w_wr, w_rd;
  logic [QUEUE_QUANTITY-1:0][DW-1:0] w_head;
  logic                             w_run, w_any, w_pop, w_err_clr;

  for (genvar g = 0; g < QUEUE_QUANTITY; g++) begin : g_vc
    qos_ingress_hold_fifo #(.DW(DW), .DEPTH(HOLD_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (w_wr[g]),
      .i_rd    (w_rd[g]),
      .i_data  (in_data),
      .o_data  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  assign w_run    = enb && (r_state == ST_RUN);
  assign in_ready = w_run && !w_full[in_vc];
  // A VC paused this very cycle must not win this cycle.
  assign w_elig   = ~w_empty & ~r_paused & ~pausa;

  always_comb begin
    int j;
    j     = 0;
    w_any = 1'b0;
    w_win = r_ptr;
    for (int k = 0; k < QUEUE_QUANTITY; k++) begin
      j = int'(r_ptr) + k;
      if (j >= QUEUE_QUANTITY) j = j - QUEUE_QUANTITY;
      if (!w_any && w_elig[j]) begin
        w_any = 1'b1;
        w_win = VW'(j);
      end
    end
  end

  assign w_pop     = w_run && w_any;
  assign w_ptr_nxt = (w_win == VW'(QUEUE_QUANTITY - 1)) ? '0 : w_win + 1'b1;

  always_comb begin
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      w_wr[i] = in_valid && in_ready && (in_vc == VW'(i));
      w_rd[i] = w_pop && (w_win == VW'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CFG:   if (cfg_start) w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_CFG;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     r_state <= ST_CFG;
    else if (enb) r_state <= w_state_nxt;
  end

  assign w_err_clr = (r_state == ST_START) || ((r_state == ST_RUN) && cfg_start);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_paused <= '0;
      r_err    <= '0;
      r_ptr    <= '0;
      r_push   <= 1'b0;
      r_vc     <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
    end else if (enb) begin
      r_paused <= (r_paused & ~continuar) | pausa;
      r_err    <= (w_err_clr ? '0 : r_err) | error_full;
      r_push   <= w_pop;
      if (w_pop) begin
        r_vc   <= w_win;
        r_data <= w_head[w_win];
        r_ptr  <= w_ptr_nxt;
        r_cnt  <= r_cnt + 1'b1;
      end
    end else begin
      // Clear so a stale push is not replayed when enable returns.
      r_push <= 1'b0;
    end
  end

  assign iniciar    = enb && (r_state == ST_START);
  assign push       = r_push && enb;
  assign vc_id      = r_vc;
  assign data_word  = r_data;
  assign paused     = r_paused;
  assign err_sticky = r_err;
  assign fwd_count  = r_cnt;
endmodule
